// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative multiply/divide unit behind a
// valid/ready request and result handshake. Multiply is shift-add, divide is
// restoring shift-subtract, one step per clock over WIDTH clocks.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;       // multiplicand
    logic [WIDTH-1:0] b_reg;       // divisor
    logic [WIDTH-1:0] hi_reg;      // product high half / partial remainder
    logic [WIDTH-1:0] lo_reg;      // multiplier -> product low / dividend -> quotient
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] out_reg;
    logic             zero_reg;
    logic             err_reg;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             is_iter;
    logic             is_mul_in;
    logic             is_mul_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH-1:0] iter_res;

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out        = out_reg;
    assign zero       = zero_reg;
    assign err        = err_reg;

    assign is_mul_in  = (ALUop[3:1] == 3'b101);
    assign is_iter    = is_mul_in || (ALUop[3:1] == 3'b110);
    assign is_mul_reg = (op_reg[3:1] == 3'b101);

    // Single-cycle result straight from the request inputs; captured on acceptance.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALUop)
            OP_AND:  alu_res = ina & inb;
            OP_OR:   alu_res = ina | inb;
            OP_ADD:  alu_res = ina + inb;
            OP_XOR:  alu_res = ina ^ inb;
            OP_SLL:  alu_res = ina << inb[SHW-1:0];
            OP_SRL:  alu_res = ina >> inb[SHW-1:0];
            OP_SUB:  alu_res = ina - inb;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (ina < inb)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ina) < $signed(inb))};
            OP_SRA:  alu_res = $unsigned($signed(ina) >>> inb[SHW-1:0]);
            4'b1110, 4'b1111: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    // One multiply or divide iteration; divide by zero falls out naturally
    // (every quotient bit sets, remainder shifts in the whole dividend).
    always_comb begin
        mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
        div_sh   = {hi_reg, lo_reg[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_reg};
        div_ge   = (div_sh >= {1'b0, b_reg});
        hi_step  = hi_reg;
        lo_step  = lo_reg;
        if (is_mul_reg) begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            hi_step = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_step = {lo_reg[WIDTH-2:0], div_ge};
        end
    end

    // Select which half of the final iteration is the answer.
    always_comb begin
        case (op_reg)
            OP_MUL:   iter_res = lo_step;
            OP_MULHU: iter_res = hi_step;
            OP_DIVU:  iter_res = lo_step;
            default:  iter_res = hi_step;
        endcase
    end

    // Handshake FSM: capture request, iterate, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
            zero_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg <= ALUop;
                        a_reg  <= ina;
                        b_reg  <= inb;
                        if (is_iter) begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_INIT;
                            hi_reg    <= '0;
                            lo_reg    <= is_mul_in ? inb : ina;
                        end else begin
                            state_reg <= DONE;
                            out_reg   <= alu_res;
                            zero_reg  <= (alu_res == '0);
                            err_reg   <= alu_err;
                        end
                    end
                end
                BUSY: begin
                    hi_reg  <= hi_step;
                    lo_reg  <= lo_step;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        out_reg   <= iter_res;
                        zero_reg  <= (iter_res == '0);
                        err_reg   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu at WIDTH=32 with hand-computed expectations.
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUop;
    logic [31:0] ina;
    logic [31:0] inb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic        err;

    int checks;
    int errors;
    int lat;
    int stale;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .ina       (ina),
        .inb       (inb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one request; returns right after the accepting edge with inputs scrambled.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        ALUop    = op;
        ina      = a;
        inb      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ALUop    = 4'($urandom);
        ina      = $urandom;
        inb      = $urandom;
    endtask

    // Wait (bounded) for out_valid; lat counts edges from the accepting edge.
    task automatic wait_done(output int l);
        int n;
        n = 0;
        l = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            l++;
            n++;
        end
        if (!out_valid) check("timeout", 0, 1);
    endtask

    // Take the result and confirm the block returns to IDLE.
    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid_low"}, out_valid, 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Full transaction with result, flags and latency compared.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_err,
                       input int exp_lat);
        int l;
        issue(op, a, b);
        wait_done(l);
        $display("%s op=%b a=%h b=%h out=%h zero=%b err=%b lat=%0d", tag, op, a, b, out, zero, err, l);
        check({tag, "_out"}, out, exp);
        check({tag, "_zero"}, zero, (exp == 32'h0));
        check({tag, "_err"}, err, exp_err);
        check({tag, "_lat"}, l, exp_lat);
        take(tag);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUop     = 4'h0;
        ina       = 32'h0;
        inb       = 32'h0;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_zero", zero, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle ops
        run("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
        run("sra",      4'b1001, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1);
        run("slt",      4'b1000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1);
        run("sltu",     4'b0111, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1);
        run("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
        run("or",       4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1);
        run("xor",      4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
        run("sll",      4'b0100, 32'h00000003, 32'h00000021, 32'h00000006, 1'b0, 1);
        run("srl",      4'b0101, 32'h80000000, 32'h0000003F, 32'h00000001, 1'b0, 1);
        run("sub",      4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1);
        run("illegal",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1);

        // Iterative ops
        run("mul",      4'b1010, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 33);
        run("mulhu",    4'b1011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 33);
        run("mul_ff",   4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
        run("mulhu_ff", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        run("divu",     4'b1100, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        run("remu",     4'b1101, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        run("divu_z",   4'b1100, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
        run("remu_z",   4'b1101, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 33);

        // Backpressure: result held, new requests ignored
        issue(4'b0010, 32'd2, 32'd3);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ALUop    = 4'b0010;
            ina      = 32'd100;
            inb      = 32'd100;
            @(posedge clk);
            #1;
            check("bp_out", out, 32'd5);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        $display("backpressure out=%h held 5 cycles", out);
        take("bp");
        @(posedge clk);
        #1;
        check("bp_no_queue", out_valid, 0);

        // Reset in the middle of a divide
        issue(4'b1100, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out", out, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);
        $display("reset mid-busy: stale results seen=%0d", stale);
        run("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from the low bits of inb.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 ALUop  input  4  operation code, encoding per REQ-012/013.
REQ-008 ina, inb  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output WIDTH result; zero  output 1  out == 0; err  output 1  illegal opcode.

Function
REQ-012 Single-cycle ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLTU, 1000 SLT (signed), 1001 SRA (arithmetic).
REQ-013 Iterative ops: 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU.
REQ-014 Opcodes 1110, 1111 illegal: result 0, zero=1, err=1, single-cycle latency.
REQ-015 Shifts use inb[SHW-1:0] only; upper inb bits ignored.
REQ-016 ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
REQ-017 SLT/SLTU produce 1 or 0 zero-extended to WIDTH.
REQ-018 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-019 Request accepted on a rising edge with in_valid && in_ready; operands and opcode captured into internal registers at acceptance; later input changes have no effect.
REQ-020 IDLE + accept of single-cycle/illegal op -> DONE, result registered on the same edge (out_valid high the cycle after acceptance).
REQ-021 IDLE + accept of iterative op -> BUSY, iteration counter loaded with WIDTH.
REQ-022 BUSY performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; after exactly WIDTH BUSY cycles -> DONE with result registered; out_valid high WIDTH+1 cycles after acceptance.
REQ-023 DONE: out, zero, err held stable while out_valid && !out_ready; DONE -> IDLE on the edge where out_ready=1.
REQ-024 out_valid = 1 only in DONE; in_valid ignored in BUSY and DONE (no queuing).
REQ-025 DIVU by zero: out = all ones; REMU by zero: out = ina; err=0; full WIDTH-cycle latency retained.
REQ-026 zero and err registered together with out; zero = (out == 0) for every op.
REQ-027 out_ready asserted outside DONE has no effect.

Reset
REQ-028 rst_n low forces, immediately and independent of clk: state=IDLE, out=0, zero=0, err=0, out_valid=0, counter=0, internal operand registers=0.
REQ-029 in_ready=1 while rst_n low and after release; first acceptance possible on the first rising edge with rst_n high.
REQ-030 Reset asserted in BUSY or DONE aborts the operation; the pending result is discarded and never presented.

Verification
REQ-031 WIDTH=32: ADD ina=0xFFFFFFFF inb=1 -> out_valid next cycle, out=0, zero=1, err=0.
REQ-032 SRA ina=0x80000000 inb=0x00000024 -> shift by 4, out=0xF8000000; SLT ina=0xFFFFFFFF inb=0 -> out=1; SLTU same -> out=0.
REQ-033 MUL ina=0x00010000 inb=0x00010000 -> out_valid exactly 33 cycles after acceptance, out=0; MULHU same operands -> out=0x00000001.
REQ-034 DIVU 100/7 -> out=14; REMU 100/7 -> out=2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 rst_n pulsed low mid-BUSY of a DIVU -> out_valid=0, out=0 immediately; after release a fresh ADD 2+3 returns 5 with no stale result observed.
